// File: rtl/axi4l_reg_slave_if.sv
// AXI4-Lite bus bundle between a master and the register slave.
// Five channels; readies/valids follow the usual AXI direction rules.
interface axi4l_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS r/w registers with byte strobes,
// independent read/write FSMs and per-register write pulses.
module axi4l_reg_slave #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axi4l_reg_slave_if.slave               s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs,
    output logic [NUM_REGS-1:0]            reg_wr
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam logic [31:0] NREGS = 32'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } wstate_t;
    typedef enum logic { R_IDLE, R_DATA } rstate_t;

    wstate_t               r_wstate;
    rstate_t               r_rstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_aw_got;
    logic                  r_w_got;
    logic [IDX_W-1:0]      r_awidx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_reg_wr;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_have;
    logic                  w_w_have;
    logic                  w_wr_fire;
    logic [IDX_W-1:0]      w_widx;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_W-1:0]     w_wstrb;
    logic                  w_wr_ok;
    logic [IDX_W-1:0]      w_ridx;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_rsel;
    logic                  w_unused;

    // Protection bits and byte offsets carry no meaning for this bank.
    assign w_unused = ^{s_axi.awprot, s_axi.arprot,
                        s_axi.awaddr[ADDR_LSB-1:0],
                        s_axi.araddr[ADDR_LSB-1:0]};

    assign w_aw_hs   = s_axi.awvalid & r_awready;
    assign w_w_hs    = s_axi.wvalid & r_wready;
    assign w_aw_have = r_aw_got | w_aw_hs;
    assign w_w_have  = r_w_got | w_w_hs;
    assign w_wr_fire = (r_wstate == W_IDLE) & w_aw_have & w_w_have;

    // A channel captured on this very edge bypasses its holding register.
    assign w_widx  = r_aw_got ? r_awidx
                              : s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
    assign w_wdata = r_w_got ? r_wdata : s_axi.wdata;
    assign w_wstrb = r_w_got ? r_wstrb : s_axi.wstrb;
    assign w_wr_ok = 32'(w_widx) < NREGS;

    assign w_ridx  = s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign w_rd_ok = 32'(w_ridx) < NREGS;

    // Read mux over the current register contents; out of range gives 0.
    always_comb begin
        w_rsel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(w_ridx) == 32'(i)) w_rsel = r_regs[i];
        end
    end

    // Write FSM: collect AW and W in any order, apply, then hold B.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_awidx   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_reg_wr  <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_reg_wr <= '0;
            unique case (r_wstate)
                W_IDLE: begin
                    if (w_wr_fire) begin
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wstate  <= W_RESP;
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (w_wr_ok && 32'(w_widx) == 32'(i)) begin
                                r_reg_wr[i] <= 1'b1;
                                for (int k = 0; k < STRB_W; k++) begin
                                    if (w_wstrb[k])
                                        r_regs[i][8*k +: 8] <= w_wdata[8*k +: 8];
                                end
                            end
                        end
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_got <= 1'b1;
                            r_awidx  <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
                        end
                        if (w_w_hs) begin
                            r_w_got <= 1'b1;
                            r_wdata <= s_axi.wdata;
                            r_wstrb <= s_axi.wstrb;
                        end
                        r_awready <= ~w_aw_have;
                        r_wready  <= ~w_w_have;
                    end
                end
                W_RESP: begin
                    if (s_axi.bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: sample the bank at the AR handshake, then hold R.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            unique case (r_rstate)
                R_IDLE: begin
                    if (s_axi.arvalid && r_arready) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_ok ? w_rsel : '0;
                        r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;
    assign reg_wr        = r_reg_wr;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
endmodule
